// File: rtl/irq_sequencer_pkg.sv
// rtl/irq_sequencer_pkg.sv - shared types and constants for the interrupt entry/exit sequencer
//
// Purpose : FSM state encoding, register-file backup (irq_bak) codes,
//           default vector address and index-width helper.
// Ports   : none (package).

package irq_sequencer_pkg;

    // Entry runs ARM -> SAVE -> ENTER, then HANDLER until return, then EXIT.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_SAVE    = 3'd2,
        ST_ENTER   = 3'd3,
        ST_HANDLER = 3'd4,
        ST_EXIT    = 3'd5
    } state_t;

    // Register-file backup controls.
    // BAK_R01       : interrupt bank captures r0/r1 from o_irq_r0/o_irq_r1
    // BAK_SP_PCNEXT : banked r13/r14 captured, r14 takes pc_next
    // BAK_SP_PCWR   : banked r13/r14 captured, r14 takes the in-flight PC write
    localparam logic [1:0] BAK_NONE      = 2'b00;
    localparam logic [1:0] BAK_R01       = 2'b01;
    localparam logic [1:0] BAK_SP_PCNEXT = 2'b10;
    localparam logic [1:0] BAK_SP_PCWR   = 2'b11;

    localparam logic [31:0] DEFAULT_VECTOR_ADDR = 32'h0000_0018;

    // Width of a source index; a single source still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - fixed-priority lowest-set-bit encoder
//
// Purpose : returns the index of the lowest set request bit (bit 0 wins).
// Ports   : i_req   [N_SRC-1:0] request vector
//           o_idx   [IDX_W-1:0] index of lowest set bit (0 when none)
//           o_valid             at least one request bit set

module irq_prio_enc #(
    parameter int N_SRC = 8,
    parameter int IDX_W = 3
) (
    input  logic [N_SRC-1:0] i_req,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    // Scan from the top down so the last hit, the lowest bit, is kept.
    always_comb begin
        o_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

    assign o_valid = |i_req;

endmodule

// File: rtl/irq_sequencer.sv
// rtl/irq_sequencer.sv - interrupt entry/exit controller for the banked register file
//
// Purpose : arbitrates N_SRC level requests, sequences the register-file
//           backup controls into the interrupt bank, switches int_mode and
//           redirects fetch to VECTOR_ADDR, then restores normal mode on return.
// Ports   : clk, rst_n (async active-low)
//           i_en          advance enable (FSM holds when low)
//           i_irq         level requests, i_irq_en global enable
//           i_boundary    instruction boundary, i_pc_en PC write in flight
//           i_ret         return-from-interrupt pulse
//           o_int_mode    register-file interrupt mode
//           o_irq_bak     register-file backup control
//           o_irq_r0/r1   granted index / request snapshot (zero-extended)
//           o_irq_ack     one-hot acknowledge in ENTER
//           o_redirect_en/o_redirect_pc  PC load to vector
//           o_flush, o_stall, o_busy  pipeline control

module irq_sequencer
    import irq_sequencer_pkg::*;
#(
    parameter int          N_SRC       = 8,
    parameter logic [31:0] VECTOR_ADDR = DEFAULT_VECTOR_ADDR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [N_SRC-1:0] i_irq,
    input  logic             i_irq_en,
    input  logic             i_boundary,
    input  logic             i_pc_en,
    input  logic             i_ret,
    output logic             o_int_mode,
    output logic [1:0]       o_irq_bak,
    output logic [31:0]      o_irq_r0,
    output logic [31:0]      o_irq_r1,
    output logic [N_SRC-1:0] o_irq_ack,
    output logic             o_redirect_en,
    output logic [31:0]      o_redirect_pc,
    output logic             o_flush,
    output logic             o_stall,
    output logic             o_busy
);

    localparam int IDX_W = idx_width(N_SRC);

    state_t             r_state;
    state_t             w_next;
    logic [IDX_W-1:0]   r_idx;
    logic [N_SRC-1:0]   r_snap;

    logic [IDX_W-1:0]   w_idx;
    logic               w_valid;
    logic               w_take;
    logic [31:0]        w_r0_ext;
    logic [31:0]        w_r1_ext;
    logic [N_SRC-1:0]   w_one;

    irq_prio_enc #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .i_req   (i_irq),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    assign w_take = i_irq_en & i_boundary & w_valid;

    // Zero-extension written as partial assignment so N_SRC == 32 needs no
    // zero-width replication.
    always_comb begin
        w_r0_ext             = '0;
        w_r0_ext[IDX_W-1:0]  = r_idx;
        w_r1_ext             = '0;
        w_r1_ext[N_SRC-1:0]  = r_snap;
        w_one                = '0;
        w_one[0]             = 1'b1;
    end

    // State and grant registers. Index/snapshot are only captured on the
    // IDLE take, so later request changes cannot disturb a committed entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_snap  <= '0;
        end else if (i_en) begin
            r_state <= w_next;
            if (r_state == ST_IDLE && w_take) begin
                r_idx  <= w_idx;
                r_snap <= i_irq;
            end
        end
    end

    // Next state and state-decoded outputs. Outputs depend on r_state (plus
    // i_pc_en in SAVE), so with i_en low they hold along with the state.
    always_comb begin
        w_next        = r_state;
        o_int_mode    = 1'b0;
        o_irq_bak     = BAK_NONE;
        o_irq_r0      = '0;
        o_irq_r1      = '0;
        o_irq_ack     = '0;
        o_redirect_en = 1'b0;
        o_redirect_pc = '0;
        o_flush       = 1'b0;
        o_stall       = 1'b0;
        o_busy        = (r_state != ST_IDLE);

        case (r_state)
            ST_IDLE: begin
                if (w_take) begin
                    w_next = ST_ARM;
                end
            end
            ST_ARM: begin
                o_irq_bak = BAK_R01;
                o_irq_r0  = w_r0_ext;
                o_irq_r1  = w_r1_ext;
                o_stall   = 1'b1;
                w_next    = ST_SAVE;
            end
            ST_SAVE: begin
                // A PC write landing this cycle must be what banked r14 keeps.
                o_irq_bak = i_pc_en ? BAK_SP_PCWR : BAK_SP_PCNEXT;
                o_stall   = 1'b1;
                w_next    = ST_ENTER;
            end
            ST_ENTER: begin
                o_int_mode    = 1'b1;
                o_redirect_en = 1'b1;
                o_redirect_pc = VECTOR_ADDR;
                o_flush       = 1'b1;
                o_irq_ack     = w_one << r_idx;
                w_next        = ST_HANDLER;
            end
            ST_HANDLER: begin
                // No nesting: requests are not looked at until back in IDLE.
                o_int_mode = 1'b1;
                if (i_ret) begin
                    w_next = ST_EXIT;
                end
            end
            ST_EXIT: begin
                // Handler already wrote PC; only the pipeline needs flushing.
                o_flush = 1'b1;
                w_next  = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_irq_sequencer.sv
// tb/tb_irq_sequencer.sv - self-checking bench for irq_sequencer

module tb_irq_sequencer;

    localparam int N = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_en = 1'b0;
    logic [N-1:0]  i_irq = '0;
    logic          i_irq_en = 1'b0;
    logic          i_boundary = 1'b0;
    logic          i_pc_en = 1'b0;
    logic          i_ret = 1'b0;
    logic          o_int_mode;
    logic [1:0]    o_irq_bak;
    logic [31:0]   o_irq_r0;
    logic [31:0]   o_irq_r1;
    logic [N-1:0]  o_irq_ack;
    logic          o_redirect_en;
    logic [31:0]   o_redirect_pc;
    logic          o_flush;
    logic          o_stall;
    logic          o_busy;

    irq_sequencer #(.N_SRC(N), .VECTOR_ADDR(32'h0000_0018)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_en          (i_en),
        .i_irq         (i_irq),
        .i_irq_en      (i_irq_en),
        .i_boundary    (i_boundary),
        .i_pc_en       (i_pc_en),
        .i_ret         (i_ret),
        .o_int_mode    (o_int_mode),
        .o_irq_bak     (o_irq_bak),
        .o_irq_r0      (o_irq_r0),
        .o_irq_r1      (o_irq_r1),
        .o_irq_ack     (o_irq_ack),
        .o_redirect_en (o_redirect_en),
        .o_redirect_pc (o_redirect_pc),
        .o_flush       (o_flush),
        .o_stall       (o_stall),
        .o_busy        (o_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: position in the entry/exit sequence.
    // 0 idle, 1..3 the three fixed entry cycles, 4 in handler, 5 exit cycle.
    int            m_pos = 0;
    int            m_idx = 0;
    logic [N-1:0]  m_snap = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against what the model says for the current
    // position and current inputs.
    task automatic check_all(input string where);
        logic [1:0]   e_bak;
        logic [N-1:0] e_ack;
        e_bak = 2'b00;
        if (m_pos == 1) e_bak = 2'b01;
        if (m_pos == 2) e_bak = i_pc_en ? 2'b11 : 2'b10;
        e_ack = (m_pos == 3) ? N'(1 << m_idx) : '0;
        chk({where, ".busy"},  32'(o_busy),        32'(m_pos != 0));
        chk({where, ".mode"},  32'(o_int_mode),    32'(m_pos == 3 || m_pos == 4));
        chk({where, ".bak"},   32'(o_irq_bak),     32'(e_bak));
        chk({where, ".r0"},    o_irq_r0,           (m_pos == 1) ? 32'(m_idx) : 32'd0);
        chk({where, ".r1"},    o_irq_r1,           (m_pos == 1) ? 32'(m_snap) : 32'd0);
        chk({where, ".ack"},   32'(o_irq_ack),     32'(e_ack));
        chk({where, ".redir"}, 32'(o_redirect_en), 32'(m_pos == 3));
        chk({where, ".pc"},    o_redirect_pc,      (m_pos == 3) ? 32'h18 : 32'd0);
        chk({where, ".flush"}, 32'(o_flush),       32'(m_pos == 3 || m_pos == 5));
        chk({where, ".stall"}, 32'(o_stall),       32'(m_pos == 1 || m_pos == 2));
    endtask

    // One clock: apply inputs, check at negedge, advance the model at posedge.
    task automatic cyc(input string where, input logic en, input logic [N-1:0] irq,
                       input logic irq_en, input logic bnd, input logic pc_en,
                       input logic ret);
        int nxt;
        i_en = en; i_irq = irq; i_irq_en = irq_en;
        i_boundary = bnd; i_pc_en = pc_en; i_ret = ret;
        @(negedge clk);
        check_all(where);
        nxt = m_pos;
        if (en) begin
            if (m_pos == 0) begin
                if (irq_en && bnd && irq != 0) begin
                    for (int b = 0; b < N; b++) begin
                        if (irq[b]) begin
                            m_idx = b;
                            break;
                        end
                    end
                    m_snap = irq;
                    nxt = 1;
                end
            end else if (m_pos == 4) begin
                if (ret) nxt = 5;
            end else if (m_pos == 5) begin
                nxt = 0;
            end else begin
                nxt = m_pos + 1;
            end
        end
        @(posedge clk);
        #1;
        m_pos = nxt;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_pos = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        cyc("reset", 1, '0, 0, 0, 0, 0);

        // Single source, no PC write in flight.
        cyc("take1",  1, 8'h04, 1, 1, 0, 0);
        chk("t1_arm_r0", o_irq_r0, 32'd2);
        chk("t1_arm_r1", o_irq_r1, 32'h4);
        chk("t1_arm_bak", 32'(o_irq_bak), 32'h1);
        cyc("arm1",   1, 8'h00, 0, 0, 0, 0);
        chk("t1_save_bak", 32'(o_irq_bak), 32'h2);
        cyc("save1",  1, 8'h00, 0, 0, 0, 0);
        chk("t1_enter_pc", o_redirect_pc, 32'h18);
        chk("t1_enter_ack", 32'(o_irq_ack), 32'h04);
        chk("t1_enter_mode", 32'(o_int_mode), 32'h1);
        cyc("enter1", 1, 8'h00, 0, 0, 0, 0);
        cyc("hdl1",   1, 8'hFF, 1, 1, 0, 0);
        cyc("hdl1r",  1, 8'h00, 1, 1, 0, 1);
        cyc("exit1",  1, 8'h00, 1, 1, 0, 0);
        cyc("idle1",  1, 8'h00, 1, 1, 0, 0);

        // Priority with PC write in flight during SAVE.
        cyc("take2",  1, 8'hA0, 1, 1, 0, 0);
        chk("t2_arm_r0", o_irq_r0, 32'd5);
        chk("t2_arm_r1", o_irq_r1, 32'hA0);
        cyc("arm2",   1, 8'h00, 1, 1, 1, 0);
        chk("t2_save_bak", 32'(o_irq_bak), 32'h3);
        // Stall in SAVE for three cycles.
        cyc("stall_a", 0, 8'h00, 1, 1, 1, 0);
        cyc("stall_b", 0, 8'h00, 1, 1, 1, 0);
        cyc("stall_c", 0, 8'h00, 1, 1, 1, 0);
        chk("t2_stall_bak", 32'(o_irq_bak), 32'h3);
        cyc("save2",  1, 8'h00, 1, 1, 1, 0);
        chk("t2_enter_ack", 32'(o_irq_ack), 32'h20);
        cyc("enter2", 1, 8'h00, 1, 1, 0, 0);
        // Return while a request is pending: return wins, re-entry after IDLE.
        cyc("hdl2r",  1, 8'h01, 1, 1, 0, 1);
        chk("t2_exit_mode", 32'(o_int_mode), 32'h0);
        chk("t2_exit_flush", 32'(o_flush), 32'h1);
        cyc("exit2",  1, 8'h01, 1, 1, 0, 0);
        chk("t2_idle_busy", 32'(o_busy), 32'h0);
        cyc("idle2",  1, 8'h01, 1, 1, 0, 0);
        chk("t2_rearm_bak", 32'(o_irq_bak), 32'h1);
        chk("t2_rearm_r0", o_irq_r0, 32'd0);

        // Reset asynchronously while in ARM.
        rst_n = 1'b0;
        m_pos = 0;
        #1;
        chk("rst_busy", 32'(o_busy), 32'h0);
        chk("rst_bak", 32'(o_irq_bak), 32'h0);
        chk("rst_r1", o_irq_r1, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Gating: enable low, then boundary low, then both high.
        cyc("gate_en",  1, 8'hFF, 0, 1, 0, 0);
        cyc("gate_bnd", 1, 8'hFF, 1, 0, 0, 0);
        cyc("gate_ret", 1, 8'hFF, 1, 0, 0, 1);
        chk("gate_idle", 32'(o_busy), 32'h0);
        cyc("gate_go",  1, 8'hFF, 1, 1, 0, 0);
        chk("gate_arm_r0", o_irq_r0, 32'd0);

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            logic [N-1:0] irq;
            irq = ($urandom_range(0, 3) == 0) ? N'($urandom) : N'(1 << $urandom_range(0, N - 1));
            if ($urandom_range(0, 4) == 0) irq = '0;
            cyc("rand",
                ($urandom_range(0, 6) != 0),
                irq,
                ($urandom_range(0, 4) != 0),
                ($urandom_range(0, 3) != 0),
                1'($urandom),
                ($urandom_range(0, 4) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
